// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared state encoding and sizing helper for the bit-serial adder
package bit_serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; never below one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single combinational full-adder cell reused every cycle
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder with start/done handshake
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Result bits gathered so far; the final bit joins them at completion
    logic [WIDTH-2:0]   r_sr_q, r_sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic               cell_sum;
    logic               cell_carry;
    logic [WIDTH-1:0]   r_ext;
    logic               accept;

    full_adder_cell u_cell (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (c_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    // New sum bit enters at the MSB while earlier bits move toward the LSB
    assign r_ext  = {cell_sum, r_sr_q};
    assign accept = start && (state_q != S_RUN);

    // Next-state logic: operand load on accept, one bit per RUN cycle, capture on last bit
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            S_RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                r_sr_d = r_ext[WIDTH-1:1];
                c_d    = cell_carry;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = r_ext;
                    carry_d = cell_carry;
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE
                if (accept) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    r_sr_d  = '0;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any addition in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule
